bsg_cache_nb_dma_sched: RTL and testbench

BSG_CACHE_NB_DMA_SCHED -- requirements
Module: bsg_cache_nb_dma_sched

---
 rtl/bsg_cache_nb_dma_sched.sv | 224 ++++++++++++++++++++++
 tb/tb_bsg_cache_nb_dma_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_cache_nb_dma_sched.sv
// rtl/bsg_cache_nb_dma_sched.sv - non-blocking cache DMA scheduler (write queue, read pass-through, refill pass-through)
//
// Purpose: queues cache eviction (write) packets and streams each block's eviction
// data to memory, passes read packets straight to memory once every earlier write
// has fully drained, limits outstanding reads to mshr_els_p, and forwards refill
// data to the cache unchanged.
//
// Ports:
//   clk_i, reset_i                                     clock, async active-high reset
//   dma_pkt_i / dma_pkt_v_i / dma_pkt_yumi_o           cache packet {write_not_read, addr, mshr_id}
//   dma_data_i / dma_data_v_i / dma_data_yumi_o        cache eviction data
//   mem_read_pkt_o / _v_o / _yumi_i                    memory read request
//   mem_write_pkt_o / _v_o / _yumi_i                   memory write request
//   mem_wdata_o / _v_o / _ready_i                      memory write data
//   mem_rdata_i / _mshr_id_i / _v_i / mem_rdata_ready_o  refill data from memory
//   refill_data_o / refill_mshr_id_o / refill_v_o / refill_ready_i  refill data to cache
//   stat_reads_o / stat_writes_o / stat_stall_o        statistics counters
//
// Configuration macro: BSG_CACHE_NB_DMA_SCHED_STATS_EN enables the statistics
// counters; without it the three stat outputs are tied to zero.

module bsg_cache_nb_dma_sched #(
    parameter int addr_width_p          = 32,
    parameter int word_width_p          = 32,
    parameter int block_size_in_words_p = 16,
    parameter int dma_data_width_p      = 256,
    parameter int mshr_els_p            = 4,
    parameter int evict_els_p           = 4
) (
    input  logic                                        clk_i,
    input  logic                                        reset_i,

    input  logic [addr_width_p+$clog2(mshr_els_p):0]    dma_pkt_i,
    input  logic                                        dma_pkt_v_i,
    output logic                                        dma_pkt_yumi_o,

    input  logic [dma_data_width_p-1:0]                 dma_data_i,
    input  logic                                        dma_data_v_i,
    output logic                                        dma_data_yumi_o,

    output logic [addr_width_p+$clog2(mshr_els_p):0]    mem_read_pkt_o,
    output logic                                        mem_read_pkt_v_o,
    input  logic                                        mem_read_pkt_yumi_i,

    output logic [addr_width_p+$clog2(mshr_els_p):0]    mem_write_pkt_o,
    output logic                                        mem_write_pkt_v_o,
    input  logic                                        mem_write_pkt_yumi_i,

    output logic [dma_data_width_p-1:0]                 mem_wdata_o,
    output logic                                        mem_wdata_v_o,
    input  logic                                        mem_wdata_ready_i,

    input  logic [dma_data_width_p-1:0]                 mem_rdata_i,
    input  logic [$clog2(mshr_els_p)-1:0]               mem_rdata_mshr_id_i,
    input  logic                                        mem_rdata_v_i,
    output logic                                        mem_rdata_ready_o,

    output logic [dma_data_width_p-1:0]                 refill_data_o,
    output logic [$clog2(mshr_els_p)-1:0]               refill_mshr_id_o,
    output logic                                        refill_v_o,
    input  logic                                        refill_ready_i,

    output logic [31:0]                                 stat_reads_o,
    output logic [31:0]                                 stat_writes_o,
    output logic [31:0]                                 stat_stall_o
);

    localparam int bursts_lp = (block_size_in_words_p * word_width_p) / dma_data_width_p;
    localparam int pkt_w_lp  = 1 + addr_width_p + $clog2(mshr_els_p);
    localparam int beat_w_lp = (bursts_lp > 1) ? $clog2(bursts_lp) : 1;
    localparam int qptr_w_lp = (evict_els_p > 1) ? $clog2(evict_els_p) : 1;
    localparam int qcnt_w_lp = $clog2(evict_els_p + 1);
    localparam int out_w_lp  = $clog2(mshr_els_p + 1);

    localparam logic [beat_w_lp-1:0] last_beat_lp = beat_w_lp'(bursts_lp - 1);
    localparam logic [qptr_w_lp-1:0] last_slot_lp = qptr_w_lp'(evict_els_p - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } wr_state_e;

    wr_state_e               r_state;
    logic [beat_w_lp-1:0]    r_wbeat;
    logic [beat_w_lp-1:0]    r_rbeat;
    logic [out_w_lp-1:0]     r_outstanding;

    logic [pkt_w_lp-1:0]     r_q_mem [evict_els_p];
    logic [qptr_w_lp-1:0]    r_q_wptr;
    logic [qptr_w_lp-1:0]    r_q_rptr;
    logic [qcnt_w_lp-1:0]    r_q_count;

    logic w_pkt_write;
    logic w_q_full;
    logic w_q_empty;
    logic w_enq;
    logic w_deq;
    logic w_wdata_xfer;
    logic w_rd_v;
    logic w_rd_accept;
    logic w_refill_xfer;
    logic w_refill_done;

    assign w_pkt_write = dma_pkt_i[pkt_w_lp-1];
    assign w_q_full    = (r_q_count == qcnt_w_lp'(evict_els_p));
    assign w_q_empty   = (r_q_count == '0);

    // Fullness is taken from the registered count, so a dequeue in the same
    // cycle never frees a slot for an enqueue on a full queue.
    assign w_enq = ~reset_i & dma_pkt_v_i & w_pkt_write & ~w_q_full;

    // Reads wait until every earlier write has finished its last data beat:
    // the queue must be empty and the write engine back in IDLE.
    assign w_rd_v = ~reset_i & dma_pkt_v_i & ~w_pkt_write & w_q_empty
                  & (r_state == IDLE) & (r_outstanding < out_w_lp'(mshr_els_p));
    assign w_rd_accept = w_rd_v & mem_read_pkt_yumi_i;

    assign w_wdata_xfer  = (r_state == DATA) & dma_data_v_i & mem_wdata_ready_i;
    assign w_deq         = w_wdata_xfer & (r_wbeat == last_beat_lp);
    assign w_refill_xfer = ~reset_i & mem_rdata_v_i & refill_ready_i;
    assign w_refill_done = w_refill_xfer & (r_rbeat == last_beat_lp);

    assign dma_pkt_yumi_o    = w_enq | w_rd_accept;
    assign mem_read_pkt_o    = dma_pkt_i;
    assign mem_read_pkt_v_o  = w_rd_v;

    assign mem_write_pkt_o   = r_q_mem[r_q_rptr];
    assign mem_write_pkt_v_o = (r_state == HDR);

    assign mem_wdata_o       = dma_data_i;
    assign mem_wdata_v_o     = (r_state == DATA) & dma_data_v_i;
    assign dma_data_yumi_o   = w_wdata_xfer;

    assign refill_data_o     = mem_rdata_i;
    assign refill_mshr_id_o  = mem_rdata_mshr_id_i;
    assign refill_v_o        = ~reset_i & mem_rdata_v_i;
    assign mem_rdata_ready_o = ~reset_i & refill_ready_i;

    // Write engine: header for the queue head, then B data beats.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_wbeat <= '0;
        end else begin
            case (r_state)
                IDLE: if (!w_q_empty) r_state <= HDR;
                HDR:  if (mem_write_pkt_yumi_i) r_state <= DATA;
                DATA: begin
                    if (w_wdata_xfer) begin
                        if (r_wbeat == last_beat_lp) begin
                            r_wbeat <= '0;
                            r_state <= IDLE;
                        end else begin
                            r_wbeat <= r_wbeat + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Queue storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clk_i) begin
        if (w_enq) r_q_mem[r_q_wptr] <= dma_pkt_i;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_q_wptr  <= '0;
            r_q_rptr  <= '0;
            r_q_count <= '0;
        end else begin
            if (w_enq) r_q_wptr <= (r_q_wptr == last_slot_lp) ? '0 : r_q_wptr + 1'b1;
            if (w_deq) r_q_rptr <= (r_q_rptr == last_slot_lp) ? '0 : r_q_rptr + 1'b1;
            if (w_enq && !w_deq)      r_q_count <= r_q_count + 1'b1;
            else if (!w_enq && w_deq) r_q_count <= r_q_count - 1'b1;
        end
    end

    // Memory returns each block's bursts back to back, so one shared beat
    // counter is enough to spot block completion.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_rbeat       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_refill_xfer) r_rbeat <= w_refill_done ? '0 : r_rbeat + 1'b1;
            if (w_rd_accept && !w_refill_done)      r_outstanding <= r_outstanding + 1'b1;
            else if (!w_rd_accept && w_refill_done) r_outstanding <= r_outstanding - 1'b1;
        end
    end

`ifdef BSG_CACHE_NB_DMA_SCHED_STATS_EN
    logic [31:0] r_stat_reads;
    logic [31:0] r_stat_writes;
    logic [31:0] r_stat_stall;
    logic        w_rd_stall;

    assign w_rd_stall = ~reset_i & dma_pkt_v_i & ~w_pkt_write & ~w_rd_v;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_stat_reads  <= '0;
            r_stat_writes <= '0;
            r_stat_stall  <= '0;
        end else begin
            if (w_rd_accept && r_stat_reads  != '1) r_stat_reads  <= r_stat_reads  + 1'b1;
            if (w_enq       && r_stat_writes != '1) r_stat_writes <= r_stat_writes + 1'b1;
            if (w_rd_stall  && r_stat_stall  != '1) r_stat_stall  <= r_stat_stall  + 1'b1;
        end
    end

    assign stat_reads_o  = r_stat_reads;
    assign stat_writes_o = r_stat_writes;
    assign stat_stall_o  = r_stat_stall;
`else
    assign stat_reads_o  = '0;
    assign stat_writes_o = '0;
    assign stat_stall_o  = '0;
`endif

endmodule

// File: tb/tb_bsg_cache_nb_dma_sched.sv
// tb/tb_bsg_cache_nb_dma_sched.sv - randomized self-checking bench for bsg_cache_nb_dma_sched

module tb_bsg_cache_nb_dma_sched;

    localparam int AW  = 32;
    localparam int DW  = 256;
    localparam int M   = 4;
    localparam int E   = 4;
    localparam int B   = (16 * 32) / DW;
    localparam int IDW = $clog2(M);
    localparam int PW  = 1 + AW + IDW;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [PW-1:0]   dma_pkt_i;
    logic            dma_pkt_v_i;
    logic            dma_pkt_yumi_o;
    logic [DW-1:0]   dma_data_i;
    logic            dma_data_v_i;
    logic            dma_data_yumi_o;
    logic [PW-1:0]   mem_read_pkt_o;
    logic            mem_read_pkt_v_o;
    logic            mem_read_pkt_yumi_i;
    logic [PW-1:0]   mem_write_pkt_o;
    logic            mem_write_pkt_v_o;
    logic            mem_write_pkt_yumi_i;
    logic [DW-1:0]   mem_wdata_o;
    logic            mem_wdata_v_o;
    logic            mem_wdata_ready_i;
    logic [DW-1:0]   mem_rdata_i;
    logic [IDW-1:0]  mem_rdata_mshr_id_i;
    logic            mem_rdata_v_i;
    logic            mem_rdata_ready_o;
    logic [DW-1:0]   refill_data_o;
    logic [IDW-1:0]  refill_mshr_id_o;
    logic            refill_v_o;
    logic            refill_ready_i;
    logic [31:0]     stat_reads_o;
    logic [31:0]     stat_writes_o;
    logic [31:0]     stat_stall_o;

    always #5 clk = ~clk;

    bsg_cache_nb_dma_sched dut (
        .clk_i                (clk),
        .reset_i              (reset_i),
        .dma_pkt_i            (dma_pkt_i),
        .dma_pkt_v_i          (dma_pkt_v_i),
        .dma_pkt_yumi_o       (dma_pkt_yumi_o),
        .dma_data_i           (dma_data_i),
        .dma_data_v_i         (dma_data_v_i),
        .dma_data_yumi_o      (dma_data_yumi_o),
        .mem_read_pkt_o       (mem_read_pkt_o),
        .mem_read_pkt_v_o     (mem_read_pkt_v_o),
        .mem_read_pkt_yumi_i  (mem_read_pkt_yumi_i),
        .mem_write_pkt_o      (mem_write_pkt_o),
        .mem_write_pkt_v_o    (mem_write_pkt_v_o),
        .mem_write_pkt_yumi_i (mem_write_pkt_yumi_i),
        .mem_wdata_o          (mem_wdata_o),
        .mem_wdata_v_o        (mem_wdata_v_o),
        .mem_wdata_ready_i    (mem_wdata_ready_i),
        .mem_rdata_i          (mem_rdata_i),
        .mem_rdata_mshr_id_i  (mem_rdata_mshr_id_i),
        .mem_rdata_v_i        (mem_rdata_v_i),
        .mem_rdata_ready_o    (mem_rdata_ready_o),
        .refill_data_o        (refill_data_o),
        .refill_mshr_id_o     (refill_mshr_id_o),
        .refill_v_o           (refill_v_o),
        .refill_ready_i       (refill_ready_i),
        .stat_reads_o         (stat_reads_o),
        .stat_writes_o        (stat_writes_o),
        .stat_stall_o         (stat_stall_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference model: pending evictions, write engine phase, block progress.
    logic [PW-1:0] m_wq[$];
    int            m_phase;      // 0 waiting, 1 header offered, 2 streaming data
    int            m_wbeats;     // data beats sent for the current eviction
    int            m_reads_open; // reads whose refill block has not fully returned
    int            m_rbeats;     // beats received of the block currently returning
    longint        m_st_rd, m_st_wr, m_st_stall;
    int            n_resets = 0;

    task automatic model_reset();
        m_wq.delete();
        m_phase = 0; m_wbeats = 0; m_reads_open = 0; m_rbeats = 0;
        m_st_rd = 0; m_st_wr = 0; m_st_stall = 0;
    endtask

    task automatic check_stats(input string tag);
`ifdef BSG_CACHE_NB_DMA_SCHED_STATS_EN
        check_val({tag, "_st_reads"},  DW'(stat_reads_o),  DW'(m_st_rd));
        check_val({tag, "_st_writes"}, DW'(stat_writes_o), DW'(m_st_wr));
        check_val({tag, "_st_stall"},  DW'(stat_stall_o),  DW'(m_st_stall));
`else
        check_val({tag, "_st_reads"},  DW'(stat_reads_o),  DW'(0));
        check_val({tag, "_st_writes"}, DW'(stat_writes_o), DW'(0));
        check_val({tag, "_st_stall"},  DW'(stat_stall_o),  DW'(0));
`endif
    endtask

    task automatic check_all_idle(input string tag);
        check_val({tag, "_rd_v"},     DW'(mem_read_pkt_v_o),  DW'(0));
        check_val({tag, "_pkt_yumi"}, DW'(dma_pkt_yumi_o),    DW'(0));
        check_val({tag, "_wr_v"},     DW'(mem_write_pkt_v_o), DW'(0));
        check_val({tag, "_wd_v"},     DW'(mem_wdata_v_o),     DW'(0));
        check_val({tag, "_dd_yumi"},  DW'(dma_data_yumi_o),   DW'(0));
        check_val({tag, "_refill_v"}, DW'(refill_v_o),        DW'(0));
    endtask

    task automatic drive_random(input int p_pkt, input int p_wr, input int p_wyumi,
                                input int p_ryumi, input int p_rdata);
        logic wnr;
        wnr                  = ($urandom_range(0, 99) < p_wr);
        dma_pkt_v_i          = ($urandom_range(0, 99) < p_pkt);
        dma_pkt_i            = {wnr, AW'($urandom), IDW'($urandom)};
        dma_data_v_i         = $urandom_range(0, 3) != 0;
        dma_data_i           = {8{$urandom}};
        mem_read_pkt_yumi_i  = ($urandom_range(0, 99) < p_ryumi);
        mem_write_pkt_yumi_i = ($urandom_range(0, 99) < p_wyumi);
        mem_wdata_ready_i    = $urandom_range(0, 3) != 0;
        mem_rdata_v_i        = (m_reads_open > 0) && ($urandom_range(0, 99) < p_rdata);
        mem_rdata_i          = {8{$urandom}};
        mem_rdata_mshr_id_i  = IDW'($urandom);
        refill_ready_i       = $urandom_range(0, 3) != 0;
    endtask

    // Compare every output with what the model expects this cycle, then
    // advance the model by the handshakes that the coming edge will commit.
    task automatic check_and_step();
        logic is_wr, exp_rd_v, exp_yumi;
        int   q0;
        is_wr    = dma_pkt_i[PW-1];
        q0       = m_wq.size();
        exp_rd_v = dma_pkt_v_i && !is_wr && q0 == 0 && m_phase == 0 && m_reads_open < M;
        exp_yumi = is_wr ? (dma_pkt_v_i && q0 < E) : (exp_rd_v && mem_read_pkt_yumi_i);

        check_val("rd_v",     DW'(mem_read_pkt_v_o), DW'(exp_rd_v));
        check_val("rd_pkt",   DW'(mem_read_pkt_o),   DW'(dma_pkt_i));
        check_val("pkt_yumi", DW'(dma_pkt_yumi_o),   DW'(exp_yumi));
        check_val("wr_v",     DW'(mem_write_pkt_v_o), DW'(m_phase == 1));
        if (m_phase == 1)
            check_val("wr_pkt", DW'(mem_write_pkt_o), DW'(m_wq[0]));
        check_val("wd_v",     DW'(mem_wdata_v_o),   DW'(m_phase == 2 && dma_data_v_i));
        check_val("dd_yumi",  DW'(dma_data_yumi_o), DW'(m_phase == 2 && dma_data_v_i && mem_wdata_ready_i));
        check_val("wdata",    mem_wdata_o, dma_data_i);
        check_val("refill_v", DW'(refill_v_o), DW'(mem_rdata_v_i));
        check_val("rdata_rdy", DW'(mem_rdata_ready_o), DW'(refill_ready_i));
        check_val("refill_d", refill_data_o, mem_rdata_i);
        check_val("refill_id", DW'(refill_mshr_id_o), DW'(mem_rdata_mshr_id_i));
        check_stats("cyc");

        if (m_phase == 2) begin
            if (dma_data_v_i && mem_wdata_ready_i) begin
                m_wbeats++;
                if (m_wbeats == B) begin
                    m_wbeats = 0;
                    void'(m_wq.pop_front());
                    m_phase = 0;
                end
            end
        end else if (m_phase == 1) begin
            if (mem_write_pkt_yumi_i) m_phase = 2;
        end else if (q0 > 0) begin
            m_phase = 1;
        end
        if (dma_pkt_v_i && is_wr && q0 < E) begin
            m_wq.push_back(dma_pkt_i);
            m_st_wr++;
        end
        if (exp_rd_v && mem_read_pkt_yumi_i) begin
            m_reads_open++;
            m_st_rd++;
        end
        if (dma_pkt_v_i && !is_wr && !exp_rd_v) m_st_stall++;
        if (mem_rdata_v_i && refill_ready_i) begin
            m_rbeats++;
            if (m_rbeats == B) begin
                m_rbeats = 0;
                m_reads_open--;
            end
        end
    endtask

    initial begin
        int p_pkt, p_wr, p_wyumi, p_ryumi, p_rdata;
        reset_i = 1'b1;
        drive_random(100, 50, 100, 100, 0);
        dma_pkt_v_i = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_idle("reset");
        check_stats("reset");
        reset_i = 1'b0;

        for (int ph = 0; ph < 5; ph++) begin
            case (ph)
                0: begin p_pkt = 60; p_wr = 40; p_wyumi = 60; p_ryumi = 70; p_rdata = 60; end
                1: begin p_pkt = 90; p_wr = 90; p_wyumi = 10; p_ryumi = 70; p_rdata = 60; end
                2: begin p_pkt = 90; p_wr = 5;  p_wyumi = 80; p_ryumi = 90; p_rdata = 0;  end
                3: begin p_pkt = 80; p_wr = 30; p_wyumi = 90; p_ryumi = 100; p_rdata = 90; end
                default: begin p_pkt = 70; p_wr = 50; p_wyumi = 50; p_ryumi = 50; p_rdata = 50; end
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                reset_i = 1'b0;
                drive_random(p_pkt, p_wr, p_wyumi, p_ryumi, p_rdata);
                #1;
                if (m_phase == 2 && m_wbeats > 0 && n_resets < 3 &&
                    (n_resets == 0 || $urandom_range(0, 3) == 0)) begin
                    // Asynchronous reset in the middle of an eviction block.
                    dma_pkt_v_i   = 1'b1;
                    dma_data_v_i  = 1'b1;
                    mem_rdata_v_i = 1'b1;
                    reset_i       = 1'b1;
                    #1;
                    check_all_idle("midrst");
                    model_reset();
                    check_stats("midrst");
                    n_resets++;
                end else begin
                    check_and_step();
                end
            end
        end

        check_val("mid_reset_seen", DW'(n_resets > 0), DW'(1));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
